ff_wb_align: RTL and testbench

//  Forward/final (FF) stage plus write-back alignment; sits directly downstream of the EX->FF register.

---
 rtl/ff_wb_align.sv | 162 ++++++++++++++++
 tb/tb_ff_wb_align.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_wb_align.sv
// ff_wb_align: FF stage result pipelines, operand forwarding,
// register-file write-back alignment and branch redirect register.
module ff_wb_align #(
  parameter int DEPTH = 6,
  parameter int AW    = 7,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [AW-1:0] ff_rtaddr_e,
  input  logic [AW-1:0] ff_rtaddr_o,
  input  logic          ff_wreg_e,
  input  logic          ff_wreg_o,
  input  logic [DW-1:0] ff_rt_e,
  input  logic [DW-1:0] ff_rt_o,
  input  logic [2:0]    ff_uid_e,
  input  logic [2:0]    ff_uid_o,
  input  logic          ff_branch_flag,
  input  logic [31:0]   ff_branch_target_addr,
  input  logic [AW-1:0] fwd_addr_ra,
  input  logic [AW-1:0] fwd_addr_rb,
  input  logic [AW-1:0] fwd_addr_rc,
  output logic [2:0]    fwd_hit,
  output logic [2:0]    fwd_busy,
  output logic [DW-1:0] fwd_data_ra,
  output logic [DW-1:0] fwd_data_rb,
  output logic [DW-1:0] fwd_data_rc,
  output logic          wb_we_e,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_e,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_data_e,
  output logic [DW-1:0] wb_data_o,
  output logic          redirect_valid,
  output logic [31:0]   redirect_addr
);

  if (DEPTH < 6) begin : g_depth_chk
    $error("ff_wb_align: DEPTH must be >= 6");
  end

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic [AW-1:0] addr;
    logic [2:0]    uid;
    logic [DW-1:0] data;
  } ent_t;

  ent_t pe [DEPTH];
  ent_t po [DEPTH];
  ent_t in_e;
  ent_t in_o;

  logic [AW-1:0] lk    [3];
  logic [DW-1:0] dat_c [3];
  logic [2:0]    hit_c;
  logic [2:0]    busy_c;

  // Entry is ready once its stage index reaches unit latency - 1.
  function automatic logic ready(input logic [2:0] uid, input int stg);
    int lat;
    case (uid)
      3'd0:    lat = 2;
      3'd1:    lat = 4;
      3'd2:    lat = 6;
      3'd3:    lat = 4;
      3'd4:    lat = 4;
      3'd5:    lat = 6;
      3'd6:    lat = 2;
      default: lat = 1;
    endcase
    return stg >= lat - 1;
  endfunction

  // Build stage-0 entries; uid 7 has no result so never writes.
  always_comb begin
    in_e.valid = ff_wreg_e;
    in_e.wreg  = ff_wreg_e & (ff_uid_e != 3'd7);
    in_e.addr  = ff_rtaddr_e;
    in_e.uid   = ff_uid_e;
    in_e.data  = ff_rt_e;
    in_o.valid = ff_wreg_o;
    in_o.wreg  = ff_wreg_o & (ff_uid_o != 3'd7);
    in_o.addr  = ff_rtaddr_o;
    in_o.uid   = ff_uid_o;
    in_o.data  = ff_rt_o;
  end

  // Shift both result pipes unless stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        pe[k] <= '0;
        po[k] <= '0;
      end
    end else if (!stall) begin
      pe[0] <= in_e;
      po[0] <= in_o;
      for (int k = 1; k < DEPTH; k++) begin
        pe[k] <= pe[k-1];
        po[k] <= po[k-1];
      end
    end
  end

  // Branch redirect toward fetch; target kept when no branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
    end else if (!stall) begin
      redirect_valid <= ff_branch_flag;
      if (ff_branch_flag) redirect_addr <= ff_branch_target_addr;
    end
  end

  // Gather lookup addresses so the three ports share one search.
  always_comb begin
    lk[0] = fwd_addr_ra;
    lk[1] = fwd_addr_rb;
    lk[2] = fwd_addr_rc;
  end

  // Search oldest to youngest so the youngest match overrides;
  // odd is visited after even so it wins within a stage.
  always_comb begin
    hit_c  = '0;
    busy_c = '0;
    for (int p = 0; p < 3; p++) begin
      dat_c[p] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (pe[k].valid && pe[k].wreg && pe[k].addr == lk[p]) begin
          hit_c[p]  = ready(pe[k].uid, k);
          busy_c[p] = !ready(pe[k].uid, k);
          dat_c[p]  = ready(pe[k].uid, k) ? pe[k].data : '0;
        end
        if (po[k].valid && po[k].wreg && po[k].addr == lk[p]) begin
          hit_c[p]  = ready(po[k].uid, k);
          busy_c[p] = !ready(po[k].uid, k);
          dat_c[p]  = ready(po[k].uid, k) ? po[k].data : '0;
        end
      end
    end
  end

  assign fwd_hit     = hit_c;
  assign fwd_busy    = busy_c;
  assign fwd_data_ra = dat_c[0];
  assign fwd_data_rb = dat_c[1];
  assign fwd_data_rc = dat_c[2];

  assign wb_we_o   = po[DEPTH-1].valid & po[DEPTH-1].wreg;
  assign wb_we_e   = pe[DEPTH-1].valid & pe[DEPTH-1].wreg
                   & ~(wb_we_o & (pe[DEPTH-1].addr == po[DEPTH-1].addr));
  assign wb_addr_e = pe[DEPTH-1].addr;
  assign wb_addr_o = po[DEPTH-1].addr;
  assign wb_data_e = pe[DEPTH-1].data;
  assign wb_data_o = po[DEPTH-1].data;

endmodule

// File: tb/tb_ff_wb_align.sv
// tb_ff_wb_align: directed scenarios plus randomized traffic
// checked against a record-list model of in-flight results.
module tb_ff_wb_align;
  localparam int DEPTH = 6;
  localparam int AW    = 7;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [AW-1:0] ff_rtaddr_e, ff_rtaddr_o;
  logic          ff_wreg_e, ff_wreg_o;
  logic [DW-1:0] ff_rt_e, ff_rt_o;
  logic [2:0]    ff_uid_e, ff_uid_o;
  logic          ff_branch_flag;
  logic [31:0]   ff_branch_target_addr;
  logic [AW-1:0] fwd_addr_ra, fwd_addr_rb, fwd_addr_rc;
  logic [2:0]    fwd_hit, fwd_busy;
  logic [DW-1:0] fwd_data_ra, fwd_data_rb, fwd_data_rc;
  logic          wb_we_e, wb_we_o;
  logic [AW-1:0] wb_addr_e, wb_addr_o;
  logic [DW-1:0] wb_data_e, wb_data_o;
  logic          redirect_valid;
  logic [31:0]   redirect_addr;

  always #5 clk = ~clk;

  ff_wb_align #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ff_rtaddr_e(ff_rtaddr_e), .ff_rtaddr_o(ff_rtaddr_o),
    .ff_wreg_e(ff_wreg_e), .ff_wreg_o(ff_wreg_o),
    .ff_rt_e(ff_rt_e), .ff_rt_o(ff_rt_o),
    .ff_uid_e(ff_uid_e), .ff_uid_o(ff_uid_o),
    .ff_branch_flag(ff_branch_flag),
    .ff_branch_target_addr(ff_branch_target_addr),
    .fwd_addr_ra(fwd_addr_ra), .fwd_addr_rb(fwd_addr_rb),
    .fwd_addr_rc(fwd_addr_rc),
    .fwd_hit(fwd_hit), .fwd_busy(fwd_busy),
    .fwd_data_ra(fwd_data_ra), .fwd_data_rb(fwd_data_rb),
    .fwd_data_rc(fwd_data_rc),
    .wb_we_e(wb_we_e), .wb_we_o(wb_we_o),
    .wb_addr_e(wb_addr_e), .wb_addr_o(wb_addr_o),
    .wb_data_e(wb_data_e), .wb_data_o(wb_data_o),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  typedef struct {
    bit            pipe;
    logic [AW-1:0] addr;
    logic [2:0]    uid;
    logic [DW-1:0] data;
    int            t;
  } rec_t;

  rec_t        q[$];
  int          tnow;
  logic        exp_rv;
  logic [31:0] exp_ra;
  int          n_cmp;
  int          n_err;
  int          lat_tab[8] = '{2, 4, 6, 4, 4, 6, 2, 1};

  task automatic model_clear();
    q.delete();
    exp_rv = 1'b0;
    exp_ra = '0;
  endtask

  task automatic tick();
    rec_t r;
    @(posedge clk);
    if (!rst && !stall) begin
      tnow++;
      if (ff_wreg_e && ff_uid_e != 3'd7) begin
        r.pipe = 0; r.addr = ff_rtaddr_e; r.uid = ff_uid_e;
        r.data = ff_rt_e; r.t = tnow;
        q.push_back(r);
      end
      if (ff_wreg_o && ff_uid_o != 3'd7) begin
        r.pipe = 1; r.addr = ff_rtaddr_o; r.uid = ff_uid_o;
        r.data = ff_rt_o; r.t = tnow;
        q.push_back(r);
      end
      exp_rv = ff_branch_flag;
      if (ff_branch_flag) exp_ra = ff_branch_target_addr;
    end
    for (int i = q.size() - 1; i >= 0; i--)
      if (tnow - q[i].t >= DEPTH) q.delete(i);
    #1;
  endtask

  function automatic void model_fwd(input logic [AW-1:0] a,
                                    output logic h, output logic b,
                                    output logic [DW-1:0] d);
    int bs = DEPTH + 1;
    int bi = -1;
    for (int i = 0; i < q.size(); i++) begin
      int s = tnow - q[i].t;
      if (q[i].addr == a && (s < bs || (s == bs && q[i].pipe))) begin
        bs = s;
        bi = i;
      end
    end
    h = 0; b = 0; d = '0;
    if (bi >= 0) begin
      if (bs >= lat_tab[q[bi].uid] - 1) begin
        h = 1; d = q[bi].data;
      end else b = 1;
    end
  endfunction

  function automatic void model_wb(output logic we, output logic wo,
                                   output logic [AW-1:0] ae,
                                   output logic [AW-1:0] ao,
                                   output logic [DW-1:0] de,
                                   output logic [DW-1:0] dd);
    we = 0; wo = 0; ae = '0; ao = '0; de = '0; dd = '0;
    foreach (q[i]) begin
      if (tnow - q[i].t == DEPTH - 1) begin
        if (q[i].pipe) begin wo = 1; ao = q[i].addr; dd = q[i].data; end
        else begin we = 1; ae = q[i].addr; de = q[i].data; end
      end
    end
  endfunction

  task automatic idle();
    stall = 0; ff_wreg_e = 0; ff_wreg_o = 0;
    ff_uid_e = 0; ff_uid_o = 0; ff_branch_flag = 0;
  endtask

  task automatic put_e(input logic [AW-1:0] a, input logic [2:0] u,
                       input logic [DW-1:0] d);
    ff_wreg_e = 1; ff_rtaddr_e = a; ff_uid_e = u; ff_rt_e = d;
  endtask

  task automatic put_o(input logic [AW-1:0] a, input logic [2:0] u,
                       input logic [DW-1:0] d);
    ff_wreg_o = 1; ff_rtaddr_o = a; ff_uid_o = u; ff_rt_o = d;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    rst = 1; idle();
    ff_rtaddr_e = 0; ff_rtaddr_o = 0; ff_rt_e = '0; ff_rt_o = '0;
    ff_branch_target_addr = '0;
    fwd_addr_ra = 0; fwd_addr_rb = 0; fwd_addr_rc = 0;
    tnow = 0; model_clear();
    repeat (2) tick();
    n_cmp++;
    if ({wb_we_e, wb_we_o, fwd_hit, fwd_busy} !== 8'h0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0",
               {wb_we_e, wb_we_o, fwd_hit, fwd_busy});
    end
    n_cmp++;
    if ({redirect_valid, redirect_addr} !== 33'h0) begin
      n_err++;
      $display("FAIL reset_redir: got %h want 0",
               {redirect_valid, redirect_addr});
    end
    n_cmp++;
    if ({wb_addr_e, wb_data_o, fwd_data_ra} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got nonzero want 0");
    end
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] d = {16{8'hA5}};
    idle(); put_e(7'd5, 3'd0, d); fwd_addr_ra = 5;
    tick(); idle();
    n_cmp++;
    if (fwd_busy[0] !== 1'b1 || fwd_hit[0] !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy: got hit=%b busy=%b want 0/1",
               fwd_hit[0], fwd_busy[0]);
    end
    tick();
    n_cmp++;
    if (fwd_hit[0] !== 1'b1 || fwd_data_ra !== d) begin
      n_err++;
      $display("FAIL basic_hit: got %b %h want 1 %h",
               fwd_hit[0], fwd_data_ra, d);
    end
    repeat (3) tick();
    n_cmp++;
    if (wb_we_e !== 1'b0) begin
      n_err++; $display("FAIL basic_early_wb: got %b want 0", wb_we_e);
    end
    tick();
    n_cmp++;
    if (wb_we_e !== 1'b1 || wb_addr_e !== 7'd5 || wb_data_e !== d) begin
      n_err++;
      $display("FAIL basic_wb: got %b %0d %h want 1 5 %h",
               wb_we_e, wb_addr_e, wb_data_e, d);
    end
    drain();
  endtask

  task automatic test_collision();
    logic [DW-1:0] de = {16{8'h11}};
    logic [DW-1:0] dd = {16{8'h22}};
    idle(); put_e(7'd9, 3'd0, de); put_o(7'd9, 3'd0, dd);
    fwd_addr_rb = 9;
    tick(); idle(); tick();
    n_cmp++;
    if (fwd_hit[1] !== 1'b1 || fwd_data_rb !== dd) begin
      n_err++;
      $display("FAIL coll_fwd: got %b %h want 1 %h",
               fwd_hit[1], fwd_data_rb, dd);
    end
    repeat (4) tick();
    n_cmp++;
    if ({wb_we_e, wb_we_o} !== 2'b01 || wb_data_o !== dd
        || wb_addr_o !== 7'd9) begin
      n_err++;
      $display("FAIL coll_wb: got %b%b %h want 01 %h",
               wb_we_e, wb_we_o, wb_data_o, dd);
    end
    drain();
  endtask

  task automatic test_youngest();
    logic [DW-1:0] d0 = {4{32'h0BAD_0000}};
    logic [DW-1:0] d2 = {4{32'h600D_2222}};
    idle(); put_e(7'd3, 3'd0, d0); fwd_addr_ra = 3;
    tick(); idle(); put_e(7'd3, 3'd2, d2);
    tick(); idle();
    n_cmp++;
    if (fwd_busy[0] !== 1'b1 || fwd_hit[0] !== 1'b0
        || fwd_data_ra !== '0) begin
      n_err++;
      $display("FAIL young_busy: got %b/%b want hit0 busy1",
               fwd_hit[0], fwd_busy[0]);
    end
    repeat (4) tick();
    n_cmp++;
    if (fwd_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL young_c6: got busy=%b want 1", fwd_busy[0]);
    end
    tick();
    n_cmp++;
    if (fwd_hit[0] !== 1'b1 || fwd_data_ra !== d2) begin
      n_err++;
      $display("FAIL young_hit: got %b %h want 1 %h",
               fwd_hit[0], fwd_data_ra, d2);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [DW-1:0] d = {4{32'h5A5A_0040}};
    idle(); put_e(7'd40, 3'd0, d);
    fwd_addr_ra = 40; fwd_addr_rb = 41;
    tick();
    stall = 1;
    put_e(7'd41, 3'd0, '1); put_o(7'd41, 3'd6, '1);
    ff_branch_flag = 1; ff_branch_target_addr = 32'hDEAD;
    repeat (3) tick();
    n_cmp++;
    if (fwd_busy[0] !== 1'b1 || fwd_hit[1] !== 1'b0
        || fwd_busy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL stall_hold: got busy=%b hit=%b want busy0 only",
               fwd_busy, fwd_hit);
    end
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_redir: got %b want 0", redirect_valid);
    end
    idle();
    repeat (4) tick();
    n_cmp++;
    if (wb_we_e !== 1'b0) begin
      n_err++; $display("FAIL stall_early: got %b want 0", wb_we_e);
    end
    tick();
    n_cmp++;
    if (wb_we_e !== 1'b1 || wb_addr_e !== 7'd40 || wb_data_e !== d) begin
      n_err++;
      $display("FAIL stall_wb: got %b %0d want 1 40", wb_we_e, wb_addr_e);
    end
    n_cmp++;
    if (fwd_hit[1] !== 1'b0 || fwd_busy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL stall_ghost: got %b/%b want 0/0",
               fwd_hit[1], fwd_busy[1]);
    end
    drain();
  endtask

  task automatic test_redirect();
    idle(); ff_branch_flag = 1; ff_branch_target_addr = 32'h100;
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h100) begin
      n_err++;
      $display("FAIL redir_set: got %b %h want 1 100",
               redirect_valid, redirect_addr);
    end
    ff_branch_flag = 0; ff_branch_target_addr = 32'h200;
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b0 || redirect_addr !== 32'h100) begin
      n_err++;
      $display("FAIL redir_hold: got %b %h want 0 100",
               redirect_valid, redirect_addr);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    fwd_addr_ra = 20; fwd_addr_rb = 21; fwd_addr_rc = 23;
    put_e(7'd20, 3'd0, '1); tick(); idle();
    put_o(7'd21, 3'd0, '1); tick(); idle();
    put_e(7'd22, 3'd0, '1); tick(); idle();
    put_o(7'd23, 3'd0, '1); tick(); idle();
    n_cmp++;
    if (fwd_hit !== 3'b011 || fwd_busy !== 3'b100) begin
      n_err++;
      $display("FAIL pre_rst: got hit=%b busy=%b want 011/100",
               fwd_hit, fwd_busy);
    end
    rst = 1; model_clear();
    #1;
    n_cmp++;
    if ({wb_we_e, wb_we_o, fwd_hit, fwd_busy} !== 8'h0) begin
      n_err++;
      $display("FAIL rst_now: got %b want 0",
               {wb_we_e, wb_we_o, fwd_hit, fwd_busy});
    end
    tick();
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if ({wb_we_e, wb_we_o, fwd_hit, fwd_busy} !== 8'h0) begin
        n_err++;
        $display("FAIL rst_after c%0d: got %b want 0", c,
                 {wb_we_e, wb_we_o, fwd_hit, fwd_busy});
      end
    end
  endtask

  task automatic test_random();
    logic          h, b, we, wo;
    logic [AW-1:0] ae, ao;
    logic [DW-1:0] d, de, dd;
    logic [AW-1:0] la [3];
    for (int c = 0; c < 600; c++) begin
      stall          = ($urandom_range(0, 4) == 0);
      ff_wreg_e      = ($urandom_range(0, 3) != 0);
      ff_wreg_o      = ($urandom_range(0, 3) != 0);
      ff_rtaddr_e    = 7'($urandom_range(0, 7));
      ff_rtaddr_o    = 7'($urandom_range(0, 7));
      ff_uid_e       = 3'($urandom);
      ff_uid_o       = 3'($urandom);
      ff_rt_e        = {$urandom, $urandom, $urandom, $urandom};
      ff_rt_o        = {$urandom, $urandom, $urandom, $urandom};
      ff_branch_flag = $urandom_range(0, 1) == 1;
      ff_branch_target_addr = $urandom;
      tick();
      if ($urandom_range(0, 60) == 0) begin
        rst = 1; model_clear(); #1; rst = 0;
      end
      la[0] = 7'($urandom_range(0, 7));
      la[1] = 7'($urandom_range(0, 7));
      la[2] = 7'($urandom_range(0, 7));
      fwd_addr_ra = la[0]; fwd_addr_rb = la[1]; fwd_addr_rc = la[2];
      #1;
      for (int p = 0; p < 3; p++) begin
        model_fwd(la[p], h, b, d);
        n_cmp++;
        if (fwd_hit[p] !== h || fwd_busy[p] !== b
            || (p == 0 ? fwd_data_ra : p == 1 ? fwd_data_rb : fwd_data_rc)
               !== d) begin
          n_err++;
          $display("FAIL rnd_fwd c%0d p%0d: got %b/%b want %b/%b data %h",
                   c, p, fwd_hit[p], fwd_busy[p], h, b, d);
        end
      end
      model_wb(we, wo, ae, ao, de, dd);
      if (we && wo && ae == ao) we = 0;
      n_cmp++;
      if (wb_we_e !== we || wb_we_o !== wo
          || (we && (wb_addr_e !== ae || wb_data_e !== de))
          || (wo && (wb_addr_o !== ao || wb_data_o !== dd))) begin
        n_err++;
        $display("FAIL rnd_wb c%0d: got we %b%b a %0d/%0d want %b%b a %0d/%0d",
                 c, wb_we_e, wb_we_o, wb_addr_e, wb_addr_o,
                 we, wo, ae, ao);
      end
      n_cmp++;
      if (redirect_valid !== exp_rv || redirect_addr !== exp_ra) begin
        n_err++;
        $display("FAIL rnd_redir c%0d: got %b %h want %b %h", c,
                 redirect_valid, redirect_addr, exp_rv, exp_ra);
      end
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_collision();
    test_youngest();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
